game_status_checker: RTL and testbench

- Consumer at the far end of the board interface: reads the 16-cell gameboard and player-ownership vectors produced by the column selector.
- Scans all 10 four-cell lines of the 4x4 board: 4 rows, 4 columns, 2 diagonals.
- Produces the 2-bit game status that the turn FSM takes as its game-status input.
- Multi-cycle scanner with a start/busy/done handshake, one line evaluated per clock.

---
 rtl/game_status_checker_if.sv | 33 +++
 rtl/game_status_checker.sv | 147 ++++++++++++++
 tb/tb_game_status_checker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/game_status_checker_if.sv
// Board/status interface between the board producer (master) and game_status_checker (slave).
// WIN_MASK_EN adds the win_cells deciding-line mask to the bundle.
interface game_status_checker_if;
  logic        start;
  logic [15:0] in_gameboard;
  logic [15:0] in_players_cells;
  logic        busy;
  logic        done;
  logic [1:0]  out_game_status;
`ifdef WIN_MASK_EN
  logic [15:0] win_cells;

  modport master (
    output start, in_gameboard, in_players_cells,
    input  busy, done, out_game_status, win_cells
  );

  modport slave (
    input  start, in_gameboard, in_players_cells,
    output busy, done, out_game_status, win_cells
  );
`else
  modport master (
    output start, in_gameboard, in_players_cells,
    input  busy, done, out_game_status
  );

  modport slave (
    input  start, in_gameboard, in_players_cells,
    output busy, done, out_game_status
  );
`endif
endinterface

// File: rtl/game_status_checker.sv
// Multi-cycle 4x4 board scanner: evaluates one of 10 lines per clock on a snapshot, reports win/draw/playing.
// Optional feature macro WIN_MASK_EN: exposes the registered cell mask of the deciding line.
module game_status_checker (
  input logic                 clk,
  input logic                 reset,
  game_status_checker_if.slave bus
);

  localparam int unsigned N_CELLS = 16;
  localparam int unsigned N_LINES = 10;
  localparam int unsigned CNT_W   = 4;

  localparam logic [1:0] ST_PLAYING = 2'b00;
  localparam logic [1:0] ST_P1_WIN  = 2'b01;
  localparam logic [1:0] ST_P2_WIN  = 2'b10;
  localparam logic [1:0] ST_DRAW    = 2'b11;

  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(N_LINES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCAN   = 2'b01,
    FINISH = 2'b10
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   line_idx;
  logic [N_CELLS-1:0] board_snap;
  logic [N_CELLS-1:0] owner_snap;
  logic               win_flag;
  logic               winner_p2;
  logic               busy_q;
  logic               done_q;
  logic [1:0]         status_q;
`ifdef WIN_MASK_EN
  logic [N_CELLS-1:0] win_line_q;
  logic [N_CELLS-1:0] win_cells_q;
`endif

  // Cell mask of each line; order fixes which line decides on illegal boards.
  function automatic logic [N_CELLS-1:0] line_mask(input logic [CNT_W-1:0] idx);
    case (idx)
      4'd0:    line_mask = 16'h000F;
      4'd1:    line_mask = 16'h00F0;
      4'd2:    line_mask = 16'h0F00;
      4'd3:    line_mask = 16'hF000;
      4'd4:    line_mask = 16'h1111;
      4'd5:    line_mask = 16'h2222;
      4'd6:    line_mask = 16'h4444;
      4'd7:    line_mask = 16'h8888;
      4'd8:    line_mask = 16'h8421;
      4'd9:    line_mask = 16'h1248;
      default: line_mask = 16'h0000;
    endcase
  endfunction

  logic [N_CELLS-1:0] mask_c;
  logic [N_CELLS-1:0] owned_c;
  logic               line_full_c;
  logic               line_same_c;
  logic               line_win_c;
  logic               line_p2_c;

  assign mask_c      = line_mask(line_idx);
  assign owned_c     = owner_snap & mask_c;
  assign line_full_c = ((board_snap & mask_c) == mask_c);
  assign line_same_c = (owned_c == '0) || (owned_c == mask_c);
  assign line_win_c  = line_full_c && line_same_c;
  assign line_p2_c   = |owned_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      line_idx   <= '0;
      board_snap <= '0;
      owner_snap <= '0;
      win_flag   <= 1'b0;
      winner_p2  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_PLAYING;
`ifdef WIN_MASK_EN
      win_line_q  <= '0;
      win_cells_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            board_snap <= bus.in_gameboard;
            owner_snap <= bus.in_players_cells;
            win_flag   <= 1'b0;
            winner_p2  <= 1'b0;
            line_idx   <= '0;
            busy_q     <= 1'b1;
            state      <= SCAN;
`ifdef WIN_MASK_EN
            win_line_q <= '0;
`endif
          end
        end
        SCAN: begin
          // First winning line sticks; later lines cannot overwrite it.
          if (line_win_c && !win_flag) begin
            win_flag  <= 1'b1;
            winner_p2 <= line_p2_c;
`ifdef WIN_MASK_EN
            win_line_q <= mask_c;
`endif
          end
          line_idx <= line_idx + CNT_W'(1);
          if (line_idx == LAST_LINE) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (win_flag) begin
            status_q <= winner_p2 ? ST_P2_WIN : ST_P1_WIN;
          end else if (&board_snap) begin
            status_q <= ST_DRAW;
          end else begin
            status_q <= ST_PLAYING;
          end
`ifdef WIN_MASK_EN
          win_cells_q <= win_flag ? win_line_q : '0;
`endif
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.out_game_status = status_q;
`ifdef WIN_MASK_EN
  assign bus.win_cells       = win_cells_q;
`endif

endmodule

// File: tb/tb_game_status_checker.sv
// Directed bench for game_status_checker; also checks win_cells when built with WIN_MASK_EN.
module tb_game_status_checker;

  localparam logic [1:0] PLAY = 2'b00;
  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;
  localparam logic [1:0] DRAW = 2'b11;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  game_status_checker_if bus ();

  game_status_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_mask(input string tag, input logic [15:0] exp_mask);
`ifdef WIN_MASK_EN
    check(tag, 32'(bus.win_cells), 32'(exp_mask));
`else
    $display("note %s expected mask %04h (mask port not built)", tag, exp_mask);
`endif
  endtask

  // One full check from start pulse to the cycle after done; optional start re-pulses and input
  // clobbering during SCAN.
  task automatic do_check(input string tag, input logic [15:0] b, input logic [15:0] p,
                          input logic [1:0] exp_st, input logic [15:0] exp_mask, input bit disturb);
    int n_done;
    int n_idle;
    n_done = 0;
    n_idle = 0;
    bus.in_gameboard     = b;
    bus.in_players_cells = p;
    bus.start            = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      if (disturb && (k == 3 || k == 7)) bus.start = 1'b1;
      if (disturb && k == 3) begin
        bus.in_gameboard     = 16'h0000;
        bus.in_players_cells = 16'h0000;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) n_done++;
      if (!bus.busy) n_idle++;
    end
    check({tag, "_busy_held"}, 32'(n_idle), 32'd0);
    check({tag, "_no_early_done"}, 32'(n_done), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    check({tag, "_status"}, 32'(bus.out_game_status), 32'(exp_st));
    check_mask({tag, "_mask"}, exp_mask);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_status_hold"}, 32'(bus.out_game_status), 32'(exp_st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    n_checks             = 0;
    n_errors             = 0;
    reset                = 1'b0;
    bus.start            = 1'b0;
    bus.in_gameboard     = 16'h0000;
    bus.in_players_cells = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_status", 32'(bus.out_game_status), 32'(PLAY));
    check_mask("rst_mask", 16'h0000);
    reset = 1'b1;
    @(posedge clk); #1;

    do_check("empty",      16'h0000, 16'h0000, PLAY, 16'h0000, 1'b0);
    do_check("row0_p1",    16'h000F, 16'h0000, P1,   16'h000F, 1'b0);
    do_check("col2_p2",    16'h4444, 16'h4444, P2,   16'h4444, 1'b1);
    do_check("draw",       16'hFFFF, 16'h3C3C, DRAW, 16'h0000, 1'b0);
    do_check("anti_p2",    16'hFFFF, 16'h3E7C, P2,   16'h1248, 1'b0);
    // Diagonal (player 1) and anti-diagonal (player 2) both win; lower index wins.
    do_check("both_lines", 16'hFFFF, 16'h1248, P1,   16'h8421, 1'b0);

    // start held high: back-to-back checks, second snapshot taken after one IDLE cycle.
    bus.in_gameboard     = 16'h000F;
    bus.in_players_cells = 16'h0000;
    bus.start            = 1'b1;
    @(posedge clk); #1;
    bus.in_gameboard = 16'h0000;
    repeat (10) @(posedge clk);
    #1;
    check("b2b_first_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("b2b_first_done", 32'(bus.done), 32'd1);
    check("b2b_first_status", 32'(bus.out_game_status), 32'(P1));
    check("b2b_idle_gap", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_restart", 32'(bus.busy), 32'd1);
    check("b2b_restart_done", 32'(bus.done), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_second_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("b2b_second_done", 32'(bus.done), 32'd1);
    check("b2b_second_status", 32'(bus.out_game_status), 32'(PLAY));
    check_mask("b2b_second_mask", 16'h0000);
    @(posedge clk); #1;

    // Reset mid-scan discards the partial result and the pending done.
    do_check("pre_reset", 16'h4444, 16'h4444, P2, 16'h4444, 1'b0);
    bus.in_gameboard     = 16'h000F;
    bus.in_players_cells = 16'h0000;
    bus.start            = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_status", 32'(bus.out_game_status), 32'(PLAY));
    check_mask("midrst_mask", 16'h0000);
    @(posedge clk); #1;
    reset  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    check("midrst_status_hold", 32'(bus.out_game_status), 32'(PLAY));
    do_check("after_reset", 16'h000F, 16'h0000, P1, 16'h000F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
